// File: rtl/hazard_ctrl_param_pkg.sv
// Shared definitions for the VeSPA hazard controller: FSM encodings,
// flush-mask constants and a small helper for sizing the hold counter.
package hazard_ctrl_param_pkg;

   // state    | meaning
   // HZ_IDLE  | watching for control events and load hazards
   // HZ_STALL | holding o_StallSignal for the remaining load-latency cycles
   // HZ_FLUSH | holding a registered flush mask
   typedef enum logic [1:0] {
      HZ_IDLE  = 2'd0,
      HZ_STALL = 2'd1,
      HZ_FLUSH = 2'd2
   } hzState_t;

   // Flush masks, bit order {M,E,D,F}.
   localparam logic [3:0] FLUSH_INT  = 4'b0111;
   localparam logic [3:0] FLUSH_BR   = 4'b1111;
   localparam logic [3:0] FLUSH_JMP  = 4'b0111;
   localparam logic [3:0] FLUSH_RETI = 4'b1111;

   function automatic int hzMax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hazard_ctrl_param_detect.sv
// Combinational load-use / load-store-data hazard compare. Kept separate so a
// forwarding unit can reuse the same Decode-vs-Execute address match.
module hazard_ctrl_param_detect #(
   parameter int REG_ADDR_W = 4
) (
   input  logic [REG_ADDR_W-1:0] i_Rs1Dec,
   input  logic [REG_ADDR_W-1:0] i_Rs2Dec,
   input  logic                  i_Rs1UsedDec,
   input  logic                  i_Rs2UsedDec,
   input  logic [REG_ADDR_W-1:0] i_RdExe,
   input  logic                  i_LoadExe,
   output logic                  o_Haz
);

   // Register 0 is deliberately not special-cased: full-width equality only.
   always_comb begin
      o_Haz = i_LoadExe &
              ((i_Rs1UsedDec & (i_Rs1Dec == i_RdExe)) |
               (i_Rs2UsedDec & (i_Rs2Dec == i_RdExe)));
   end

endmodule

// File: rtl/hazard_ctrl_param.sv
// Pipeline hazard controller between Decode/Execute and the pipeline-register
// enables: load-hazard stalls, prioritised registered flushes, deferred
// interrupt acceptance.
//
// state    | meaning
// HZ_IDLE  | accept irq > branch > jump > RETI > load hazard
// HZ_STALL | stall held, events ignored, irq only latched as pending
// HZ_FLUSH | mask held via down-counter, irq only latched as pending
module hazard_ctrl_param
   import hazard_ctrl_param_pkg::*;
#(
   parameter int REG_ADDR_W      = 4,
   parameter int LD_STALL_CYCLES = 1,
   parameter int FLUSH_HOLD      = 1
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic [REG_ADDR_W-1:0] i_Rs1Dec,
   input  logic [REG_ADDR_W-1:0] i_Rs2Dec,
   input  logic                  i_Rs1UsedDec,
   input  logic                  i_Rs2UsedDec,
   input  logic [REG_ADDR_W-1:0] i_RdExe,
   input  logic                  i_LoadExe,
   input  logic                  i_BranchTakenExe,
   input  logic                  i_JmpExe,
   input  logic                  i_RetiExe,
   input  logic                  i_InterruptReq,
   output logic                  o_FlushFetch,
   output logic                  o_FlushDecode,
   output logic                  o_FlushExecute,
   output logic                  o_FlushMemory,
   output logic                  o_StallSignal,
   output logic                  o_IntAck,
   output logic                  o_IntPending
);

   localparam int CNT_W = $clog2(hzMax(LD_STALL_CYCLES, FLUSH_HOLD) + 1);
   // The first stall cycle is issued from IDLE, so STALL covers the rest.
   localparam logic [CNT_W-1:0] STALL_LOAD =
      CNT_W'((LD_STALL_CYCLES > 1) ? (LD_STALL_CYCLES - 2) : 0);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_HOLD - 1);

   hzState_t         state, stateNxt;
   logic [CNT_W-1:0] cnt, cntNxt;
   logic [3:0]       mask, maskNxt;
   logic             intAck, intAckNxt;
   logic             pend, pendNxt;
   logic             haz;
   logic             irq;
   logic             stall;

   hazard_ctrl_param_detect #(
      .REG_ADDR_W(REG_ADDR_W)
   ) u_detect (
      .i_Rs1Dec    (i_Rs1Dec),
      .i_Rs2Dec    (i_Rs2Dec),
      .i_Rs1UsedDec(i_Rs1UsedDec),
      .i_Rs2UsedDec(i_Rs2UsedDec),
      .i_RdExe     (i_RdExe),
      .i_LoadExe   (i_LoadExe),
      .o_Haz       (haz)
   );

   assign irq = i_InterruptReq | pend;

   // Next-state, counter, mask and interrupt bookkeeping.
   always_comb begin
      stateNxt  = state;
      cntNxt    = cnt;
      maskNxt   = mask;
      intAckNxt = 1'b0;
      pendNxt   = pend;
      stall     = 1'b0;
      case (state)
         HZ_IDLE: begin
            if (irq) begin
               maskNxt   = FLUSH_INT;
               intAckNxt = 1'b1;
               pendNxt   = 1'b0;
               stateNxt  = HZ_FLUSH;
               cntNxt    = FLUSH_LOAD;
            end else if (i_BranchTakenExe) begin
               maskNxt  = FLUSH_BR;
               stateNxt = HZ_FLUSH;
               cntNxt   = FLUSH_LOAD;
            end else if (i_JmpExe) begin
               maskNxt  = FLUSH_JMP;
               stateNxt = HZ_FLUSH;
               cntNxt   = FLUSH_LOAD;
            end else if (i_RetiExe) begin
               maskNxt  = FLUSH_RETI;
               stateNxt = HZ_FLUSH;
               cntNxt   = FLUSH_LOAD;
            end else if (haz) begin
               stall = 1'b1;
               if (LD_STALL_CYCLES > 1) begin
                  stateNxt = HZ_STALL;
                  cntNxt   = STALL_LOAD;
               end
            end
         end
         HZ_STALL: begin
            stall = 1'b1;
            if (i_InterruptReq) pendNxt = 1'b1;
            if (cnt == '0) stateNxt = HZ_IDLE;
            else           cntNxt   = cnt - CNT_W'(1);
         end
         HZ_FLUSH: begin
            if (i_InterruptReq) pendNxt = 1'b1;
            if (cnt == '0) begin
               stateNxt = HZ_IDLE;
               maskNxt  = 4'b0000;
            end else begin
               cntNxt = cnt - CNT_W'(1);
            end
         end
         default: begin
            stateNxt = HZ_IDLE;
            cntNxt   = '0;
            maskNxt  = 4'b0000;
         end
      endcase
   end

   // State register; reset aborts any stall or flush in progress.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state  <= HZ_IDLE;
         cnt    <= '0;
         mask   <= 4'b0000;
         intAck <= 1'b0;
         pend   <= 1'b0;
      end else begin
         state  <= stateNxt;
         cnt    <= cntNxt;
         mask   <= maskNxt;
         intAck <= intAckNxt;
         pend   <= pendNxt;
      end
   end

   assign o_FlushFetch   = mask[0];
   assign o_FlushDecode  = mask[1];
   assign o_FlushExecute = mask[2];
   assign o_FlushMemory  = mask[3];
   assign o_StallSignal  = stall;
   assign o_IntAck       = intAck;
   assign o_IntPending   = pend;

endmodule
